// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: merges the CPU instruction-fetch and data SRAM-like ports
// onto a single AXI3 master. At most one inst read and one data access are in
// flight; read responses are steered back to their port by rid.
module axi_sram_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,

    // instruction fetch port
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    // data access port
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    // AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    // R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    // AW channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    // W channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    // B channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_e;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

    ar_state_e   ar_state_q, ar_state_d;
    w_state_e    w_state_q,  w_state_d;

    logic        inst_pend_q, inst_pend_d;
    logic        data_pend_q, data_pend_d;

    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arid_q,   arid_d;
    logic [2:0]  arsize_q, arsize_d;

    logic [31:0] awaddr_q, awaddr_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;

    logic        ar_data_gnt, ar_inst_gnt, w_gnt;
    logic        r_inst_hit, r_data_hit, b_done;

    // Inputs with no function in this bridge (fetch is read-only, responses are not checked)
    logic        unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             rresp, rlast, bid, bresp};

    // Grant and response decode; data reads win the AR slot over fetches
    always_comb begin
        ar_data_gnt = (ar_state_q == AR_IDLE) & data_sram_req & ~data_sram_wr & ~data_pend_q;
        ar_inst_gnt = (ar_state_q == AR_IDLE) & inst_sram_req & ~inst_pend_q & ~ar_data_gnt;
        w_gnt       = (w_state_q == W_IDLE) & data_sram_req & data_sram_wr & ~data_pend_q;
        r_inst_hit  = rvalid & (rid == INST_ID);
        r_data_hit  = rvalid & (rid == DATA_ID);
        b_done      = (w_state_q == W_RESP) & bvalid;
    end

    // AR FSM next state and request-field capture
    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        arid_d     = arid_q;
        arsize_d   = arsize_q;
        unique case (ar_state_q)
            AR_IDLE: begin
                if (ar_data_gnt) begin
                    araddr_d   = data_sram_addr;
                    arid_d     = DATA_ID;
                    arsize_d   = {1'b0, data_sram_size};
                    ar_state_d = AR_BUSY;
                end else if (ar_inst_gnt) begin
                    araddr_d   = inst_sram_addr;
                    arid_d     = INST_ID;
                    arsize_d   = {1'b0, inst_sram_size};
                    ar_state_d = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (arready) begin
                    ar_state_d = AR_IDLE;
                end
            end
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // W FSM next state; AW and W handshakes complete independently
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (w_gnt) begin
                    awaddr_d  = data_sram_addr;
                    awsize_d  = {1'b0, data_sram_size};
                    wdata_d   = data_sram_wdata;
                    wstrb_d   = data_sram_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_SEND;
                end
            end
            W_SEND: begin
                if (awready) aw_done_d = 1'b1;
                if (wready)  w_done_d  = 1'b1;
                if ((aw_done_q | awready) & (w_done_q | wready)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Outstanding-request flags; a new grant cannot coincide with its own response
    always_comb begin
        inst_pend_d = inst_pend_q;
        data_pend_d = data_pend_q;
        if (r_inst_hit)              inst_pend_d = 1'b0;
        if (ar_inst_gnt)             inst_pend_d = 1'b1;
        if (r_data_hit | b_done)     data_pend_d = 1'b0;
        if (ar_data_gnt | w_gnt)     data_pend_d = 1'b1;
    end

    // State and field registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_q  <= AR_IDLE;
            w_state_q   <= W_IDLE;
            inst_pend_q <= 1'b0;
            data_pend_q <= 1'b0;
            araddr_q    <= '0;
            arid_q      <= '0;
            arsize_q    <= '0;
            awaddr_q    <= '0;
            awsize_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            ar_state_q  <= ar_state_d;
            w_state_q   <= w_state_d;
            inst_pend_q <= inst_pend_d;
            data_pend_q <= data_pend_d;
            araddr_q    <= araddr_d;
            arid_q      <= arid_d;
            arsize_q    <= arsize_d;
            awaddr_q    <= awaddr_d;
            awsize_q    <= awsize_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign inst_sram_addr_ok = ar_inst_gnt;
    assign inst_sram_data_ok = r_inst_hit;
    assign inst_sram_rdata   = rdata;
    assign data_sram_addr_ok = ar_data_gnt | w_gnt;
    assign data_sram_data_ok = r_data_hit | b_done;
    assign data_sram_rdata   = rdata;

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = (ar_state_q == AR_BUSY);
    assign arlen   = '0;
    assign arburst = 2'b01;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

    // rready follows reset directly so it drops with no clock edge
    assign rready  = aresetn;

    assign awid    = DATA_ID;
    assign awaddr  = awaddr_q;
    assign awsize  = awsize_q;
    assign awvalid = (w_state_q == W_SEND) & ~aw_done_q;
    assign awlen   = '0;
    assign awburst = 2'b01;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;

    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (w_state_q == W_SEND) & ~w_done_q;

    assign bready  = (w_state_q == W_RESP);

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed testbench for axi_sram_bridge with hand-computed expectations.
module tb_axi_sram_bridge;

    logic        aclk;
    logic        aresetn;

    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int unsigned n_checks;
    int unsigned n_errs;

    axi_sram_bridge #(
        .INST_ID(4'd0),
        .DATA_ID(4'd1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive point: just after the rising edge
    task automatic to_drive;
        @(posedge aclk);
        #1;
    endtask

    // Sample point: falling edge, away from the active edge
    task automatic at_sample;
        @(negedge aclk);
    endtask

    task automatic clear_inputs;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_addr = 0;
        inst_sram_wstrb = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 0;
        data_sram_wstrb = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        aresetn  = 0;
        clear_inputs();

        // ---------------- reset state ----------------
        to_drive();
        to_drive();
        at_sample();
        check_eq("rst_arvalid", 32'(arvalid), 0);
        check_eq("rst_awvalid", 32'(awvalid), 0);
        check_eq("rst_wvalid",  32'(wvalid), 0);
        check_eq("rst_bready",  32'(bready), 0);
        check_eq("rst_rready",  32'(rready), 0);
        check_eq("rst_araddr",  araddr, 0);
        check_eq("rst_awaddr",  awaddr, 0);
        check_eq("rst_wdata",   wdata, 0);
        check_eq("rst_wstrb",   32'(wstrb), 0);
        check_eq("ar_consts", 32'({arlen, arburst, arlock, arcache, arprot}),
                 32'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
        check_eq("aw_consts", 32'({awlen, awburst, awlock, awcache, awprot}),
                 32'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
        check_eq("w_ids", 32'({awid, wid, wlast}), 32'({4'd1, 4'd1, 1'b1}));

        // ---------------- 1: single inst read ----------------
        to_drive();
        aresetn = 1;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2;
        at_sample();
        check_eq("t1_rready", 32'(rready), 1);
        check_eq("t1_iaok", 32'(inst_sram_addr_ok), 1);
        check_eq("t1_arvalid0", 32'(arvalid), 0);
        to_drive();
        inst_sram_req = 0;
        at_sample();
        check_eq("t1_arvalid1", 32'(arvalid), 1);
        check_eq("t1_araddr", araddr, 32'h1c000000);
        check_eq("t1_arid", 32'(arid), 0);
        check_eq("t1_arsize", 32'(arsize), 2);
        check_eq("t1_iaok_pulse", 32'(inst_sram_addr_ok), 0);
        to_drive();
        arready = 1;
        at_sample();
        check_eq("t1_arvalid2", 32'(arvalid), 1);
        to_drive();
        arready = 0;
        rvalid = 1; rid = 0; rdata = 32'h02800c0c;
        at_sample();
        check_eq("t1_arvalid_drop", 32'(arvalid), 0);
        check_eq("t1_idok", 32'(inst_sram_data_ok), 1);
        check_eq("t1_irdata", inst_sram_rdata, 32'h02800c0c);
        check_eq("t1_ddok", 32'(data_sram_data_ok), 0);
        to_drive();
        rvalid = 0;
        at_sample();
        check_eq("t1_idok_pulse", 32'(inst_sram_data_ok), 0);

        // ---------------- 2: simultaneous reads, data wins ----------------
        to_drive();
        inst_sram_req = 1; inst_sram_addr = 32'h1c000004; inst_sram_size = 2;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c0a0000; data_sram_size = 2;
        at_sample();
        check_eq("t2_daok", 32'(data_sram_addr_ok), 1);
        check_eq("t2_iaok0", 32'(inst_sram_addr_ok), 0);
        to_drive();
        data_sram_req = 0;
        arready = 1;
        at_sample();
        check_eq("t2_arvalid", 32'(arvalid), 1);
        check_eq("t2_arid", 32'(arid), 1);
        check_eq("t2_araddr", araddr, 32'h1c0a0000);
        check_eq("t2_iaok_hs", 32'(inst_sram_addr_ok), 0);
        to_drive();
        arready = 0;
        at_sample();
        check_eq("t2_arvalid_gap", 32'(arvalid), 0);
        check_eq("t2_iaok1", 32'(inst_sram_addr_ok), 1);
        to_drive();
        inst_sram_req = 0;
        arready = 1;
        at_sample();
        check_eq("t2_arid_inst", 32'(arid), 0);
        check_eq("t2_araddr_inst", araddr, 32'h1c000004);

        // ---------------- 6: foreign rid dropped, pend flags kept ----------------
        to_drive();
        arready = 0;
        rvalid = 1; rid = 3; rdata = 32'h33333333;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000008;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c0a0010;
        at_sample();
        check_eq("t6_idok", 32'(inst_sram_data_ok), 0);
        check_eq("t6_ddok", 32'(data_sram_data_ok), 0);
        check_eq("t6_iaok", 32'(inst_sram_addr_ok), 0);
        check_eq("t6_daok", 32'(data_sram_addr_ok), 0);

        // ---------------- 4: out-of-order read returns ----------------
        to_drive();
        inst_sram_req = 0; data_sram_req = 0;
        rvalid = 1; rid = 1; rdata = 32'hdeadbeef;
        at_sample();
        check_eq("t4_ddok", 32'(data_sram_data_ok), 1);
        check_eq("t4_idok0", 32'(inst_sram_data_ok), 0);
        check_eq("t4_drdata", data_sram_rdata, 32'hdeadbeef);
        to_drive();
        rid = 0; rdata = 32'h11223344;
        at_sample();
        check_eq("t4_idok", 32'(inst_sram_data_ok), 1);
        check_eq("t4_ddok0", 32'(data_sram_data_ok), 0);
        check_eq("t4_irdata", inst_sram_rdata, 32'h11223344);
        to_drive();
        rvalid = 0;

        // ---------------- 3: data write, AW before W ----------------
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c0a0004; data_sram_size = 1;
        data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h00001234;
        at_sample();
        check_eq("t3_daok", 32'(data_sram_addr_ok), 1);
        check_eq("t3_awvalid0", 32'(awvalid), 0);
        to_drive();
        data_sram_req = 0; data_sram_wr = 0;
        awready = 1;
        at_sample();
        check_eq("t3_awvalid", 32'(awvalid), 1);
        check_eq("t3_wvalid", 32'(wvalid), 1);
        check_eq("t3_awaddr", awaddr, 32'h1c0a0004);
        check_eq("t3_awsize", 32'(awsize), 1);
        check_eq("t3_wdata", wdata, 32'h00001234);
        check_eq("t3_wstrb", 32'(wstrb), 32'h3);
        to_drive();
        awready = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c0a0020; data_sram_size = 2;
        at_sample();
        check_eq("t3_awvalid_drop", 32'(awvalid), 0);
        check_eq("t3_wvalid_hold", 32'(wvalid), 1);
        check_eq("t3_daok_blocked1", 32'(data_sram_addr_ok), 0);
        to_drive();
        at_sample();
        check_eq("t3_wvalid_hold2", 32'(wvalid), 1);
        to_drive();
        wready = 1;
        at_sample();
        check_eq("t3_wvalid_hs", 32'(wvalid), 1);
        check_eq("t3_bready0", 32'(bready), 0);
        to_drive();
        wready = 0;
        at_sample();
        check_eq("t3_bready", 32'(bready), 1);
        check_eq("t3_wvalid_drop", 32'(wvalid), 0);
        check_eq("t3_daok_blocked2", 32'(data_sram_addr_ok), 0);
        check_eq("t3_ddok_early", 32'(data_sram_data_ok), 0);
        to_drive();
        bvalid = 1;
        at_sample();
        check_eq("t3_ddok", 32'(data_sram_data_ok), 1);
        check_eq("t3_daok_blocked3", 32'(data_sram_addr_ok), 0);
        to_drive();
        bvalid = 0;
        at_sample();
        check_eq("t3_bready_drop", 32'(bready), 0);
        check_eq("t3_ddok_pulse", 32'(data_sram_data_ok), 0);
        check_eq("t3_daok_after", 32'(data_sram_addr_ok), 1);
        to_drive();
        data_sram_req = 0;
        arready = 1;
        at_sample();
        check_eq("t3_rd_araddr", araddr, 32'h1c0a0020);
        to_drive();
        arready = 0;
        rvalid = 1; rid = 1; rdata = 32'h0badf00d;
        at_sample();
        check_eq("t3_rd_ddok", 32'(data_sram_data_ok), 1);
        to_drive();
        rvalid = 0;

        // ---------------- 5: asynchronous reset mid-transaction ----------------
        inst_sram_req = 1; inst_sram_addr = 32'h1c000100; inst_sram_size = 2;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c0a0008; data_sram_size = 2;
        data_sram_wstrb = 4'hf; data_sram_wdata = 32'ha5a5a5a5;
        at_sample();
        check_eq("t5_iaok", 32'(inst_sram_addr_ok), 1);
        check_eq("t5_daok", 32'(data_sram_addr_ok), 1);
        to_drive();
        clear_inputs();
        at_sample();
        check_eq("t5_arvalid", 32'(arvalid), 1);
        check_eq("t5_awvalid", 32'(awvalid), 1);
        check_eq("t5_wvalid", 32'(wvalid), 1);
        #1;
        aresetn = 0;
        #1;
        check_eq("t5_arvalid_rst", 32'(arvalid), 0);
        check_eq("t5_awvalid_rst", 32'(awvalid), 0);
        check_eq("t5_wvalid_rst", 32'(wvalid), 0);
        check_eq("t5_rready_rst", 32'(rready), 0);
        to_drive();
        aresetn = 1;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000200; inst_sram_size = 2;
        at_sample();
        check_eq("t5_iaok_new", 32'(inst_sram_addr_ok), 1);
        to_drive();
        inst_sram_req = 0;
        at_sample();
        check_eq("t5_arvalid_new", 32'(arvalid), 1);
        check_eq("t5_araddr_new", araddr, 32'h1c000200);
        check_eq("t5_awvalid_new", 32'(awvalid), 0);

        to_drive();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
